seq_det_ctrl: RTL and testbench

SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

---
 rtl/seq_det_ctrl.sv | 154 +++++++++++++++
 tb/tb_seq_det_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: serial 4-bit sequence detector over one word at a time.
// An accepted word is scanned MSB first, one bit per cycle. Matches against
// the captured pattern are counted, and the count is reported through a
// valid/ready handshake. Overlapping or non-overlapping detection is chosen
// per word.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a word; in_ready high unless in reset
// SHIFT  | evaluating one bit per cycle, W cycles in total
// REPORT | match_cnt frozen, out_valid high until out_ready
module seq_det_ctrl #(
    parameter int W     = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             res,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic [3:0]       pattern,
    input  logic             overlap,
    output logic             ser_bit,
    output logic             det_pulse,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int IDX_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Per-word copies of the inputs, frozen at accept.
    logic [W-1:0]     word_q;
    logic [3:0]       pat_q;
    logic             ovl_q;

    // Bit position, counted down from W-1 to 0; position 0 is the last bit.
    logic [IDX_W-1:0] idx;
    logic [2:0]       hist;
    logic [1:0]       fill;

    logic             accept;
    logic             last_bit;
    logic             cur_bit;
    logic             match;
    logic [2:0]       hist_nxt;
    logic [1:0]       fill_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    // State register.
    always_ff @(posedge clk) begin
        if (res) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        last_bit  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !res;
                accept   = in_valid && !res;
                if (accept) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                last_bit = (idx == '0);
                if (last_bit) begin
                    state_nxt = REPORT;
                end
            end
            REPORT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Bit evaluation: match detection and the history/fill/count updates it implies.
    always_comb begin
        cur_bit  = word_q[idx];
        ser_bit  = (state == SHIFT) ? cur_bit : 1'b0;
        match    = (state == SHIFT) && (fill == 2'd3) && ({hist, cur_bit} == pat_q);
        hist_nxt = {hist[1:0], cur_bit};
        fill_nxt = (fill == 2'd3) ? 2'd3 : fill + 2'd1;
        cnt_nxt  = match_cnt;
        if (match) begin
            cnt_nxt = (match_cnt == CNT_MAX) ? CNT_MAX : match_cnt + 1'b1;
            if (!ovl_q) begin
                // Non-overlapping: the matched bits cannot start another match.
                hist_nxt = 3'b000;
                fill_nxt = 2'd0;
            end else begin
                fill_nxt = 2'd3;
            end
        end
    end

    // Word capture and scan datapath; every accept starts from a clean history.
    always_ff @(posedge clk) begin
        if (res) begin
            word_q    <= '0;
            pat_q     <= '0;
            ovl_q     <= 1'b0;
            idx       <= '0;
            hist      <= '0;
            fill      <= '0;
            match_cnt <= '0;
            det_pulse <= 1'b0;
        end else begin
            det_pulse <= match;
            if (accept) begin
                word_q    <= in_data;
                pat_q     <= pattern;
                ovl_q     <= overlap;
                idx       <= IDX_LAST;
                hist      <= '0;
                fill      <= '0;
                match_cnt <= '0;
            end else if (state == SHIFT) begin
                hist      <= hist_nxt;
                fill      <= fill_nxt;
                match_cnt <= cnt_nxt;
                if (!last_bit) begin
                    idx <= idx - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: directed vectors plus random words
// checked against a sliding-window reference model.
module tb_seq_det_ctrl;

    localparam int W     = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             res;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic [3:0]       pattern;
    logic             overlap;
    logic             ser_bit;
    logic             det_pulse;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] match_cnt;

    int errors = 0;
    int checks = 0;

    seq_det_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .res       (res),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .pattern   (pattern),
        .overlap   (overlap),
        .ser_bit   (ser_bit),
        .det_pulse (det_pulse),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .match_cnt (match_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Slide a 4-bit window over the word in time order; in non-overlapping
    // mode a window may only start after the end of the previous match.
    function automatic void model(input logic [W-1:0] data, input logic [3:0] pat,
                                  input logic ovl, output logic [W-1:0] mask,
                                  output int cnt);
        int last_end;
        int raw;
        logic [3:0] win;
        last_end = -1;
        raw      = 0;
        mask     = '0;
        for (int k = 3; k < W; k++) begin
            win = {data[W-1-(k-3)], data[W-1-(k-2)], data[W-1-(k-1)], data[W-1-k]};
            if (win == pat && (ovl || (k - 3) > last_end)) begin
                mask[k]  = 1'b1;
                raw      = raw + 1;
                last_end = k;
            end
        end
        cnt = (raw > (2**CNT_W - 1)) ? (2**CNT_W - 1) : raw;
    endfunction

    task automatic run_word(input logic [W-1:0] data, input logic [3:0] pat,
                            input logic ovl, input int stall, input string name,
                            output logic [CNT_W-1:0] got);
        logic [W-1:0] mask;
        int           exp;
        int           waited;
        logic         exp_pulse;
        model(data, pat, ovl, mask, exp);
        waited = 0;
        while (in_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s accept_wait: in_ready=%b required 1", name, in_ready);
        end
        in_data   = data;
        pattern   = pat;
        overlap   = ovl;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        for (int k = 0; k < W; k++) begin
            in_data  = W'($urandom);
            pattern  = 4'($urandom);
            overlap  = 1'($urandom);
            in_valid = 1'($urandom);
            exp_pulse = (k == 0) ? 1'b0 : mask[k-1];
            checks++;
            if (ser_bit !== data[W-1-k]) begin
                errors++;
                $display("FAIL %s ser_bit k=%0d: got %b required %b", name, k, ser_bit, data[W-1-k]);
            end
            checks++;
            if (det_pulse !== exp_pulse) begin
                errors++;
                $display("FAIL %s det_pulse k=%0d: got %b required %b", name, k, det_pulse, exp_pulse);
            end
            checks++;
            if ({out_valid, in_ready} !== 2'b00) begin
                errors++;
                $display("FAIL %s shift_flags k=%0d: out_valid,in_ready=%b required 00", name, k, {out_valid, in_ready});
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s out_valid_latency: got %b required 1", name, out_valid);
        end
        checks++;
        if (det_pulse !== mask[W-1]) begin
            errors++;
            $display("FAIL %s det_pulse_last: got %b required %b", name, det_pulse, mask[W-1]);
        end
        checks++;
        if (match_cnt !== CNT_W'(exp)) begin
            errors++;
            $display("FAIL %s match_cnt: got %0d required %0d", name, match_cnt, exp);
        end
        got      = match_cnt;
        in_valid = 1'b1;
        for (int s = 0; s < stall; s++) begin
            tick();
            checks++;
            if ({out_valid, in_ready, det_pulse} !== 3'b100 || match_cnt !== CNT_W'(exp)) begin
                errors++;
                $display("FAIL %s report_hold s=%0d: out_valid,in_ready,det_pulse=%b cnt=%0d required 100 cnt=%0d",
                         name, s, {out_valid, in_ready, det_pulse}, match_cnt, exp);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL %s return_idle: out_valid,in_ready=%b required 01", name, {out_valid, in_ready});
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        res = 1'b1;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset in_ready_during_res: got %b required 0", in_ready);
        end
        res = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, det_pulse, ser_bit} !== 4'b1000 || match_cnt !== '0) begin
            errors++;
            $display("FAIL reset outputs: in_ready,out_valid,det_pulse,ser_bit=%b cnt=%0d required 1000 cnt=0",
                     {in_ready, out_valid, det_pulse, ser_bit}, match_cnt);
        end
    endtask

    task automatic test_directed();
        logic [CNT_W-1:0] got;
        run_word(8'b10110110, 4'b1011, 1'b1, 0, "d_1011_ovl", got);
        checks++;
        if (got !== 4'd2) begin errors++; $display("FAIL d_1011_ovl const: got %0d required 2", got); end
        run_word(8'b10110110, 4'b1011, 1'b0, 0, "d_1011_novl", got);
        checks++;
        if (got !== 4'd1) begin errors++; $display("FAIL d_1011_novl const: got %0d required 1", got); end
        run_word(8'hFF, 4'b1111, 1'b1, 1, "d_ff_ovl", got);
        checks++;
        if (got !== 4'd5) begin errors++; $display("FAIL d_ff_ovl const: got %0d required 5", got); end
        run_word(8'hFF, 4'b1111, 1'b0, 2, "d_ff_novl", got);
        checks++;
        if (got !== 4'd2) begin errors++; $display("FAIL d_ff_novl const: got %0d required 2", got); end
    endtask

    task automatic test_report_stall();
        logic [CNT_W-1:0] got;
        run_word(8'b10110110, 4'b1011, 1'b1, 5, "stall5", got);
        checks++;
        if (got !== 4'd2) begin errors++; $display("FAIL stall5 const: got %0d required 2", got); end
    endtask

    task automatic test_reset_mid();
        logic [CNT_W-1:0] got;
        in_data  = 8'h00;
        pattern  = 4'b0000;
        overlap  = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        res = 1'b1;
        tick();
        checks++;
        if ({out_valid, det_pulse, ser_bit, in_ready} !== 4'b0000 || match_cnt !== '0) begin
            errors++;
            $display("FAIL rst_shift outputs: out_valid,det_pulse,ser_bit,in_ready=%b cnt=%0d required 0000 cnt=0",
                     {out_valid, det_pulse, ser_bit, in_ready}, match_cnt);
        end
        res = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_shift in_ready_after: got %b required 1", in_ready); end
        for (int i = 0; i < W + 2; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_shift no_result i=%0d: out_valid=%b required 0", i, out_valid); end
        end
        run_word(8'h00, 4'b0000, 1'b1, 0, "rst_shift_next", got);
        checks++;
        if (got !== 4'd5) begin errors++; $display("FAIL rst_shift_next const: got %0d required 5", got); end

        in_data  = 8'hFF;
        pattern  = 4'b1111;
        overlap  = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < W; i++) tick();
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_report pre: out_valid=%b required 1", out_valid); end
        res = 1'b1;
        tick();
        res = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01 || match_cnt !== '0) begin
            errors++;
            $display("FAIL rst_report post: out_valid,in_ready=%b cnt=%0d required 01 cnt=0", {out_valid, in_ready}, match_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [CNT_W-1:0] got;
        run_word(8'b10110000, 4'b1011, 1'b1, 0, "b2b_first", got);
        checks++;
        if (got !== 4'd1) begin errors++; $display("FAIL b2b_first const: got %0d required 1", got); end
        run_word(8'b00001011, 4'b1011, 1'b1, 0, "b2b_second", got);
        checks++;
        if (got !== 4'd1) begin errors++; $display("FAIL b2b_second const: got %0d required 1", got); end
    endtask

    task automatic test_random();
        logic [CNT_W-1:0] got;
        logic [W-1:0]     d;
        logic [3:0]       p;
        for (int i = 0; i < 40; i++) begin
            d = W'($urandom);
            p = 4'($urandom);
            // Bias some words toward dense patterns so matches are frequent.
            if (i % 4 == 0) begin
                p = {p[3], p[3], p[3], p[3]};
                d = p[3] ? 8'hFF ^ W'($urandom_range(0, 3)) : W'($urandom_range(0, 3));
            end
            run_word(d, p, 1'($urandom), $urandom_range(0, 3), "random", got);
        end
    endtask

    initial begin
        res       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        pattern   = '0;
        overlap   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_directed();
        test_report_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
